// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci pair serializer: term word, stored pair and output phase.
package fib_pkg;

  localparam int unsigned FIB_W = 16;

  typedef logic [FIB_W-1:0] fib_word_t;

  typedef struct packed {
    fib_word_t num;
    fib_word_t num2;
  } fib_pair_t;

  // Which half of the head pair is currently presented on the output.
  typedef enum logic {
    PH_NUM  = 1'b0,
    PH_NUM2 = 1'b1
  } phase_t;

endpackage

// File: rtl/fib_pair_fifo.sv
// Pair FIFO: DEPTH entries of fib_pair_t, power-of-two pointers that wrap naturally,
// and an occupancy count one bit wider than the pointers.
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  fib_pair_t wr_pair,
  output logic      full,
  output logic      empty,
  output fib_pair_t rd_pair
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fib_pair_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rd_pair = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_pair;
  end

endmodule

// File: rtl/fib_pair_serializer.sv
// Re-emits buffered Fibonacci term pairs one term per cycle and flags 16-bit wrap.
// Optional FIB_SEQ_CHECK_EN adds a sticky check that each term is the sum of the previous two.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int unsigned DATA_W = FIB_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_num,
  input  logic [DATA_W-1:0] in_num2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wrap,
  output logic              seq_err
);

  fib_pair_t wr_pair;
  fib_pair_t rd_pair;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      xfer;
  phase_t    phase;
  fib_word_t cur;
  fib_word_t prev;

  fib_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_pair (wr_pair),
    .full    (full),
    .empty   (empty),
    .rd_pair (rd_pair)
  );

  // Handshakes depend only on registered occupancy, never on out_ready.
  always_comb begin
    wr_pair.num  = FIB_W'(in_num);
    wr_pair.num2 = FIB_W'(in_num2);
    in_ready     = rst && !full;
    push         = in_valid && in_ready;
    out_valid    = !empty;
    cur          = (phase == PH_NUM) ? rd_pair.num : rd_pair.num2;
    out_data     = DATA_W'(cur);
    xfer         = out_valid && out_ready;
    pop          = xfer && (phase == PH_NUM2);
    out_wrap     = out_valid && (cur < prev);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= PH_NUM;
      prev  <= '0;
    end else if (xfer) begin
      phase <= (phase == PH_NUM) ? PH_NUM2 : PH_NUM;
      prev  <= cur;
    end
  end

`ifdef FIB_SEQ_CHECK_EN
  // prev doubles as the most recent term; p2 is the one before it.
  fib_word_t p2;
  logic [1:0] emit_cnt;
  logic      seq_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      p2        <= '0;
      emit_cnt  <= '0;
      seq_err_q <= 1'b0;
    end else if (xfer) begin
      if ((emit_cnt == 2'd2) && (cur != FIB_W'(prev + p2))) seq_err_q <= 1'b1;
      if (emit_cnt != 2'd2) emit_cnt <= emit_cnt + 2'd1;
      p2 <= prev;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule
